ex_commit_stage: RTL and testbench
==================================

# ex_commit_stage

Execute-commit stage that sits directly downstream of the 32-bit ALU. Each cycle it can take one ALU result plus its N/Z/C/V flags, a destination register index and condition/flag-set controls. It evaluates the instruction's 4-bit condition code against the architectural NZCV status register, and updates NZCV for flag-setting instructions. Instructions that pass their condition go into a 2-entry output buffer with a valid/ready handshake toward writeback; instructions that fail are annulled and counted.

## Interface
- DATA_W, 32, result width (matches ALU)
- RD_W, 4, destination register index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept this cycle
- in_result  in  DATA_W  ALU result
- in_flags  in  4  ALU flags {N,Z,C,V}
- in_rd  in  RD_W  destination register
- in_wb  in  1  instruction writes a register
- in_setf  in  1  instruction updates NZCV
- in_cond  in  4  condition code
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  buffer head valid
- out_ready  in  1  writeback accepts head
- out_result  out  DATA_W  head result
- out_rd  out  RD_W  head destination
- out_wb  out  1  head register-write enable
- nzcv  out  4  architectural flags {N,Z,C,V}
- annul_cnt  out  16  annulled-instruction count, saturating

## Operation
- Reset is asynchronous and active-low. While rst_n=0 all of the following hold:
  - nzcv=0, annul_cnt=0.
  - Buffer is empty: out_valid=0, out_result=0, out_rd=0, out_wb=0.
  - in_ready=0.
  - After release, in_ready=1 from the first clock edge.
- The condition `pass` is a combinational function of the registered nzcv and in_cond:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0
- Accept = in_valid & in_ready & !flush.
- On accept with pass=1:
  - If in_setf=1, nzcv <= in_flags.
  - The entry {in_result, in_rd, in_wb} is written at the buffer tail.
- On accept with pass=0:
  - Nothing is enqueued and nzcv is unchanged.
  - annul_cnt increments, holding at 16'hFFFF once it reaches that value.
- Pop = out_valid & out_ready & !flush. It removes the head entry; the second entry, if present, becomes the head.
- Buffer rules:
  - It is 2 entries deep and in-order.
  - in_ready is a registered signal equal to (count<2) after the edge.
  - Accept and pop in the same cycle leave count unchanged.
  - The enqueued entry lands behind any remaining entry.
- flush=1:
  - The buffer empties at the next edge.
  - Any accept or pop in that cycle is discarded: no nzcv update, no annul_cnt change.
  - nzcv and annul_cnt otherwise keep their values.
- out_result, out_rd and out_wb hold the head entry while out_valid=1. They hold their last values when the buffer is empty; writeback qualifies them with out_valid.

## Timing
- Latency is 1 cycle: an entry accepted at edge k shows out_valid=1 after edge k.
- The nzcv update is visible after the accepting edge, so a dependent conditional instruction in the very next cycle sees the new flags.
- Full throughput is one instruction per cycle while out_ready=1.
- With out_ready=0, two accepts fill the buffer. in_ready then drops after the second edge and rises one cycle after the first pop.
- out_valid, the head data and in_ready all come from flops. in_ready has no combinational path from out_ready.
- Reset mid-operation discards buffered entries immediately; no partial writeback is emitted.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, nzcv=0, annul_cnt=0, in_ready=0; after release, in_ready=1 on the next edge.
- **Flag dependency:** send SUBS with in_flags=4'b0100 and setf=1, then next cycle EQ with result 32'h5, rd=3 -> nzcv=4'b0100; the second entry emerges with out_result=5, out_rd=3; annul_cnt=0.
- **Annul:** with nzcv=4'b0000 send GT, then LE -> GT enqueued; LE annulled, annul_cnt=1, nzcv unchanged even when LE has setf=1.
- **Backpressure:** out_ready=0, three back-to-back valid AL entries A, B, C -> A and B accepted, in_ready=0 while C is held; raise out_ready -> A, B, C delivered in order, with no drop or duplication.
- **Flush:** buffer holds 2 entries and the flush cycle carries in_valid=1 with setf=1 -> buffer empty, out_valid=0 next cycle, nzcv unchanged, in_ready=1.
- **Saturation and NV:** preload by sending 65536 NV instructions -> annul_cnt=16'hFFFF; one more NV -> stays 16'hFFFF; no entry is ever enqueued.

Source files
------------

// File: rtl/ex_commit_if.sv
// Handshake bundle between the ALU-side producer, the commit stage, and writeback.
// The stage uses the slave view; the producer/writeback side uses the master view.
interface ex_commit_if #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic [3:0]        in_flags;
   logic [RD_W-1:0]   in_rd;
   logic              in_wb;
   logic              in_setf;
   logic [3:0]        in_cond;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [RD_W-1:0]   out_rd;
   logic              out_wb;

   modport master (
      output in_valid, in_result, in_flags, in_rd, in_wb, in_setf, in_cond, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_wb
   );

   modport slave (
      input  in_valid, in_result, in_flags, in_rd, in_wb, in_setf, in_cond, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_wb
   );
endinterface

// File: rtl/ex_commit_stage.sv
// Execute-commit stage: condition check against NZCV, flag update, annul counting,
// and a 2-entry in-order output buffer toward writeback.
module ex_commit_stage #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   ex_commit_if.slave          bus,
   input  logic                flush,
   output logic [3:0]          nzcv,
   output logic [15:0]         annul_cnt
);
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [RD_W-1:0]   rd;
      logic              wb;
   } ent_t;

   logic [3:0]  r_nzcv;
   logic [15:0] r_annul;
   ent_t        r_ent0, r_ent1;
   logic        r_vld0, r_vld1;
   logic        r_in_ready;

   logic        w_pass, w_acc, w_enq, w_pop;
   logic [1:0]  w_cnt, w_cnt_nxt;
   ent_t        w_new;

   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = r_nzcv;

   always_comb begin
      w_pass = 1'b0;
      case (bus.in_cond)
         4'h0: w_pass = w_z;
         4'h1: w_pass = !w_z;
         4'h2: w_pass = w_c;
         4'h3: w_pass = !w_c;
         4'h4: w_pass = w_n;
         4'h5: w_pass = !w_n;
         4'h6: w_pass = w_v;
         4'h7: w_pass = !w_v;
         4'h8: w_pass = w_c && !w_z;
         4'h9: w_pass = !w_c || w_z;
         4'hA: w_pass = (w_n == w_v);
         4'hB: w_pass = (w_n != w_v);
         4'hC: w_pass = !w_z && (w_n == w_v);
         4'hD: w_pass = w_z || (w_n != w_v);
         4'hE: w_pass = 1'b1;
         default: w_pass = 1'b0;
      endcase
   end

   assign w_acc = bus.in_valid && r_in_ready && !flush;
   assign w_enq = w_acc && w_pass;
   assign w_pop = r_vld0 && bus.out_ready && !flush;
   assign w_new = '{result: bus.in_result, rd: bus.in_rd, wb: bus.in_wb};

   // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally
   assign w_cnt     = {1'b0, r_vld0} + {1'b0, r_vld1};
   assign w_cnt_nxt = flush ? 2'd0 : (w_cnt + {1'b0, w_enq} - {1'b0, w_pop});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nzcv     <= '0;
         r_annul    <= '0;
         r_ent0     <= '0;
         r_ent1     <= '0;
         r_vld0     <= 1'b0;
         r_vld1     <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         if (w_enq && bus.in_setf) r_nzcv <= bus.in_flags;
         if (w_acc && !w_pass && r_annul != 16'hFFFF) r_annul <= r_annul + 16'd1;
         r_in_ready <= (w_cnt_nxt < 2'd2);
         if (flush) begin
            r_vld0 <= 1'b0;
            r_vld1 <= 1'b0;
         end else begin
            // head stays in ent0; data is left untouched when the buffer drains
            case ({w_enq, w_pop})
               2'b01: begin
                  if (r_vld1) r_ent0 <= r_ent1;
                  r_vld0 <= r_vld1;
                  r_vld1 <= 1'b0;
               end
               2'b10: begin
                  if (r_vld0) begin
                     r_ent1 <= w_new;
                     r_vld1 <= 1'b1;
                  end else begin
                     r_ent0 <= w_new;
                     r_vld0 <= 1'b1;
                  end
               end
               2'b11: begin
                  if (r_vld1) begin
                     r_ent0 <= r_ent1;
                     r_ent1 <= w_new;
                  end else begin
                     r_ent0 <= w_new;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.out_valid  = r_vld0;
   assign bus.out_result = r_ent0.result;
   assign bus.out_rd     = r_ent0.rd;
   assign bus.out_wb     = r_ent0.wb;
   assign nzcv           = r_nzcv;
   assign annul_cnt      = r_annul;
endmodule

// File: tb/tb_ex_commit_stage.sv
// Directed bench for ex_commit_stage: scoreboard of expected writeback entries,
// checked by a negedge monitor, plus directed flag/counter/handshake checks.
module tb_ex_commit_stage;
   typedef struct packed {
      logic [31:0] r;
      logic [3:0]  rd;
      logic        wb;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [3:0]  nzcv;
   logic [15:0] annul_cnt;

   ex_commit_if #(.DATA_W(32), .RD_W(4)) bus ();

   ex_commit_stage #(.DATA_W(32), .RD_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .flush     (flush),
      .nzcv      (nzcv),
      .annul_cnt (annul_cnt)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   ent_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_pass(input logic [3:0] f, input logic [3:0] c);
      logic n, z, cy, v, b;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0: b = z;
         3'd1: b = cy;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = cy & ~z;
         3'd5: b = (n ~^ v);
         3'd6: b = ~z & (n ~^ v);
         default: b = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? ~b : b;
   endfunction

   // Writeback monitor: every pop must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
         if (sb.size() == 0) begin
            chk("unexpected_pop", {bus.out_result[27:0], bus.out_rd}, 32'hFFFF_FFFF);
         end else begin
            ent_t e;
            e = sb.pop_front();
            chk("wb_result", bus.out_result, e.r);
            chk("wb_rd", {28'd0, bus.out_rd}, {28'd0, e.rd});
            chk("wb_wen", {31'd0, bus.out_wb}, {31'd0, e.wb});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] fl,
                        input logic [3:0] rd, input logic wb, input logic setf,
                        input logic [3:0] cond);
      bus.in_valid  = v;
      bus.in_result = res;
      bus.in_flags  = fl;
      bus.in_rd     = rd;
      bus.in_wb     = wb;
      bus.in_setf   = setf;
      bus.in_cond   = cond;
   endtask

   task automatic push(input logic [31:0] res, input logic [3:0] rd, input logic wb);
      sb.push_back('{r: res, rd: rd, wb: wb});
   endtask

   logic [3:0]  exp_nzcv;
   logic [15:0] exp_cnt;

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b1, 32'hDEAD, 4'hF, 4'h1, 1'b1, 1'b1, 4'hE);
      repeat (3) tick();
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_result", bus.out_result, 32'd0);
      chk("rst_nzcv", {28'd0, nzcv}, 32'd0);
      chk("rst_annul", {16'd0, annul_cnt}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Flag dependency: SUBS sets Z, next-cycle EQ must see it
      drive(1'b1, 32'h7, 4'b0100, 4'h1, 1'b1, 1'b1, 4'hE); push(32'h7, 4'h1, 1'b1);
      tick();
      chk("subs_nzcv", {28'd0, nzcv}, 32'h4);
      chk("subs_latency", {31'd0, bus.out_valid}, 32'd1);
      drive(1'b1, 32'h5, 4'b0000, 4'h3, 1'b1, 1'b0, 4'h0); push(32'h5, 4'h3, 1'b1);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("dep_annul", {16'd0, annul_cnt}, 32'd0);

      // Annul: GT passes, LE with setf is annulled and leaves nzcv alone
      drive(1'b1, 32'h9, 4'b0000, 4'h2, 1'b1, 1'b1, 4'hE); push(32'h9, 4'h2, 1'b1);
      tick();
      drive(1'b1, 32'h11, 4'b0000, 4'h4, 1'b0, 1'b0, 4'hC); push(32'h11, 4'h4, 1'b0);
      tick();
      drive(1'b1, 32'h22, 4'b1111, 4'h5, 1'b1, 1'b1, 4'hD);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("annul_cnt", {16'd0, annul_cnt}, 32'd1);
      chk("annul_nzcv", {28'd0, nzcv}, 32'd0);

      // Condition sweep across every flag combination
      exp_cnt = 16'd1;
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            drive(1'b1, 32'h100 + f, 4'(f), 4'hA, 1'b1, 1'b1, 4'hE);
            push(32'h100 + f, 4'hA, 1'b1);
            tick();
            drive(1'b1, 32'h1000 + 32'(f * 16 + c), 4'(~f), 4'(c), 1'b1, 1'b0, 4'(c));
            if (model_pass(4'(f), 4'(c))) push(32'h1000 + 32'(f * 16 + c), 4'(c), 1'b1);
            else exp_cnt++;
            tick();
         end
      end
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("sweep_annul", {16'd0, annul_cnt}, {16'd0, exp_cnt});
      chk("sweep_nzcv", {28'd0, nzcv}, 32'hF);
      exp_nzcv = 4'hF;

      // Backpressure: A, B fill the buffer, C waits for space
      bus.out_ready = 1'b0;
      drive(1'b1, 32'hA, 4'h0, 4'h6, 1'b1, 1'b0, 4'hE); push(32'hA, 4'h6, 1'b1);
      tick();
      chk("bp_ready_1", {31'd0, bus.in_ready}, 32'd1);
      drive(1'b1, 32'hB, 4'h0, 4'h7, 1'b0, 1'b0, 4'hE); push(32'hB, 4'h7, 1'b0);
      tick();
      chk("bp_ready_full", {31'd0, bus.in_ready}, 32'd0);
      drive(1'b1, 32'hC, 4'h0, 4'h8, 1'b1, 1'b0, 4'hE); push(32'hC, 4'h8, 1'b1);
      tick();
      tick();
      chk("bp_ready_held", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_head", bus.out_result, 32'hA);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);
      chk("bp_sb_empty", sb.size(), 32'd0);

      // Flush with a full buffer and a flag-setting instruction presented
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h51, 4'h0, 4'h1, 1'b1, 1'b0, 4'hE); push(32'h51, 4'h1, 1'b1);
      tick();
      drive(1'b1, 32'h52, 4'h0, 4'h2, 1'b1, 1'b0, 4'hE); push(32'h52, 4'h2, 1'b1);
      tick();
      flush = 1'b1;
      drive(1'b1, 32'h53, 4'b1010, 4'h3, 1'b1, 1'b1, 4'hE);
      tick();
      sb.delete();
      chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_nzcv", {28'd0, nzcv}, {28'd0, exp_nzcv});
      chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
      // While ready: flush must also discard an accept and an annul
      tick();
      chk("flush2_nzcv", {28'd0, nzcv}, {28'd0, exp_nzcv});
      chk("flush2_out_valid", {31'd0, bus.out_valid}, 32'd0);
      drive(1'b1, 32'h54, 4'h0, 4'h4, 1'b1, 1'b1, 4'hF);
      tick();
      chk("flush_annul", {16'd0, annul_cnt}, {16'd0, exp_cnt});
      flush = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 0, 0);

      // Reset mid-operation drops buffered entries immediately
      drive(1'b1, 32'h61, 4'h0, 4'h5, 1'b1, 1'b0, 4'hE);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst_annul", {16'd0, annul_cnt}, 32'd0);
      sb.delete();
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();

      // Saturation with NV instructions
      drive(1'b1, 32'h77, 4'hF, 4'h9, 1'b1, 1'b1, 4'hF);
      repeat (65534) tick();
      chk("sat_65534", {16'd0, annul_cnt}, 32'hFFFE);
      tick();
      chk("sat_65535", {16'd0, annul_cnt}, 32'hFFFF);
      tick();
      chk("sat_65536", {16'd0, annul_cnt}, 32'hFFFF);
      tick();
      chk("sat_hold", {16'd0, annul_cnt}, 32'hFFFF);
      chk("nv_no_entry", {31'd0, bus.out_valid}, 32'd0);
      chk("nv_nzcv", {28'd0, nzcv}, 32'd0);
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("final_sb_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
